fc_argmax: RTL and testbench
============================

// Module: fc_argmax
// PURPOSE
//  Classifier back-end downstream of the LeNet FC2 layer. On fc2_done it reads the FC2 class
//  scores from SRAM f, finds the highest signed score and presents {class_id, class_score}
//  through a valid/ready handshake to the host/testbench result port.
// PARAMETERS
//  CLASS_NUM       10  number of class scores stored in SRAM f (1..16)
//  DATA_WIDTH       8  width of one class score, signed two's complement
//  BYTES_PER_WORD   4  scores per SRAM f word
//  ADDR_WIDTH       2  SRAM f read address width
// PORTS
//  clk            in   1   clock, all state on rising edge
//  srstn          in   1   reset, asynchronous, active-low
//  fc2_done       in   1   1-cycle pulse: FC2 scores complete in SRAM f
//  sram_raddr_f   out  2   SRAM f read address (ADDR_WIDTH)
//  sram_rdata_f   in   32  SRAM f read data, valid 1 cycle after address (BYTES_PER_WORD*DATA_WIDTH)
//  busy           out  1   high from scan start until result handshake completes
//  class_valid    out  1   result valid, held until accepted
//  class_ready    in   1   consumer accepts result when class_valid & class_ready
//  class_id       out  4   index of winning class
//  class_score    out  8   winning score (DATA_WIDTH), signed
// BEHAVIOUR
//  Reset: sram_raddr_f=0, busy=0, class_valid=0, class_id=0, class_score=0, FSM=IDLE, all counters 0.
//  Layout: class k at word k/BYTES_PER_WORD, lane L=k%BYTES_PER_WORD in bits [8*(3-L)+7 -: 8]
//   (lane 0 = MSB byte). Bytes with index >= CLASS_NUM in the last word are ignored.
//  Words scanned: NW = ceil(CLASS_NUM/BYTES_PER_WORD) = 3 by default.
//  FSM IDLE -> SCAN -> DONE -> IDLE:
//   IDLE: fc2_done=1 -> SCAN, busy<=1, sram_raddr_f<=0, running max <= most negative value, idx<=0.
//   SCAN: sram_raddr_f increments each cycle until NW-1 issued, then holds; registered flag
//    rd_vld delays address by 1 cycle to mark data valid; one word compared per valid cycle.
//    After the word at NW-1 is compared -> DONE, class_valid<=1, class_id/class_score loaded.
//   DONE: outputs stable while class_valid & !class_ready. On handshake: class_valid<=0, busy<=0,
//    -> IDLE; if fc2_done is high in that same cycle it starts a new scan (-> SCAN) directly.
//  Latency (default params): fc2_done at cycle 0 -> addr 0,1,2 on cycles 1,2,3; data compared
//   cycles 2,3,4; class_valid=1 at cycle 5. Throughput: one word per cycle, no bubbles.
//  Compare: signed; replace only on strictly greater, scanning classes in ascending index,
//   so ties resolve to the lowest class index. Per-word 4-lane reduction is combinational,
//   merged with running max in one cycle; no arithmetic beyond compares, no saturation.
//  fc2_done in SCAN, or in DONE without handshake: ignored (no queueing, no error flag).
//  sram_raddr_f holds its last value outside SCAN; never exceeds NW-1.
//  srstn low at any time (incl. mid-scan or DONE): immediate return to reset values; a partial
//   result is discarded and never asserted.
//  class_id width fixed 4 bits; CLASS_NUM>16 is illegal (elaboration-time check).
// TESTING
//  1 scores class0..9 = {-5,3,0,12,-128,7,1,100,99,-1}, pulse fc2_done at cycle 0, ready=1
//    -> class_valid rises cycle 5, class_id=7, class_score=8'h64, one-cycle valid, busy low cycle 6.
//  2 all scores -3 except class9=-3, class4=-4 -> class_id=0, class_score=8'hFD (tie -> lowest).
//  3 classes all 8'h80, unused bytes (class 10,11 lanes) = 8'h7F -> class_id=0, class_score=8'h80.
//  4 class_ready low 20 cycles after valid, extra fc2_done pulse at cycle 8 -> id/score/valid
//    stable, extra pulse ignored; ready=1 -> valid drops next cycle, no second result.
//  5 srstn low at cycle 3 of a scan, released cycle 5 -> all outputs reset, class_valid never
//    asserts; next fc2_done gives correct result at +5 cycles.
//  6 back-to-back: fc2_done coincident with handshake cycle, new scores (max class 2 = 8'h40)
//    -> second result class_id=2 valid 5 cycles after that handshake; sram_raddr_f sequence 0,1,2.

Source files
------------

// File: rtl/fc_argmax_if.sv
// Result/SRAM bundle between the argmax back-end (slave) and the host/SRAM side (master).
interface fc_argmax_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int BYTES_PER_WORD = 4,
    parameter int ADDR_WIDTH     = 2
);
    logic                                 fc2_done;
    logic [ADDR_WIDTH-1:0]                sram_raddr_f;
    logic [BYTES_PER_WORD*DATA_WIDTH-1:0] sram_rdata_f;
    logic                                 busy;
    logic                                 class_valid;
    logic                                 class_ready;
    logic [3:0]                           class_id;
    logic [DATA_WIDTH-1:0]                class_score;

    modport slave (
        input  fc2_done, sram_rdata_f, class_ready,
        output sram_raddr_f, busy, class_valid, class_id, class_score
    );

    modport master (
        output fc2_done, sram_rdata_f, class_ready,
        input  sram_raddr_f, busy, class_valid, class_id, class_score
    );
endinterface

// File: rtl/fc_argmax.sv
// Scans the FC2 class scores in SRAM f after fc2_done and returns the index/value of the
// highest signed score (lowest index on ties) through a valid/ready result port.
module fc_argmax #(
    parameter int CLASS_NUM      = 10,
    parameter int DATA_WIDTH     = 8,
    parameter int BYTES_PER_WORD = 4,
    parameter int ADDR_WIDTH     = 2
) (
    input  logic        clk,
    input  logic        srstn,
    fc_argmax_if.slave  bus
);
    localparam int NW = (CLASS_NUM + BYTES_PER_WORD - 1) / BYTES_PER_WORD;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NW - 1);
    localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    if (CLASS_NUM < 1 || CLASS_NUM > 16) begin : g_bad_class_num
        $error("fc_argmax: CLASS_NUM must be 1..16");
    end
    if (NW > (1 << ADDR_WIDTH)) begin : g_bad_addr_width
        $error("fc_argmax: ADDR_WIDTH too small for CLASS_NUM");
    end

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                        r_state, w_next;
    logic [ADDR_WIDTH-1:0]         r_raddr, r_rd_addr;
    logic                          r_rd_vld, r_iss_done;
    logic                          r_busy, r_valid;
    logic [3:0]                    r_id, r_idx;
    logic signed [DATA_WIDTH-1:0]  r_score, r_max;

    logic                          w_start, w_hs, w_issue, w_finish;
    logic signed [DATA_WIDTH-1:0]  w_best, w_lane;
    logic [3:0]                    w_best_id;

    // State register
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.fc2_done) w_next = SCAN;
            SCAN:    if (w_finish)     w_next = DONE;
            DONE:    if (w_hs)         w_next = bus.fc2_done ? SCAN : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Control strobes decoded from the current state
    always_comb begin
        w_hs     = (r_state == DONE) && r_valid && bus.class_ready;
        w_start  = ((r_state == IDLE) || w_hs) && bus.fc2_done;
        w_issue  = (r_state == SCAN) && !r_iss_done;
        w_finish = (r_state == SCAN) && r_rd_vld && (r_rd_addr == LAST);
    end

    // Lanes are taken in ascending class order and only a strictly greater score
    // replaces the running max, so ties keep the lowest index.
    always_comb begin
        w_best    = r_max;
        w_best_id = r_idx;
        w_lane    = '0;
        for (int l = 0; l < BYTES_PER_WORD; l++) begin
            w_lane = signed'(bus.sram_rdata_f[DATA_WIDTH*(BYTES_PER_WORD-1-l) +: DATA_WIDTH]);
            if ((int'(r_rd_addr) * BYTES_PER_WORD + l) < CLASS_NUM && w_lane > w_best) begin
                w_best    = w_lane;
                w_best_id = 4'(int'(r_rd_addr) * BYTES_PER_WORD + l);
            end
        end
    end

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            r_raddr    <= '0;
            r_rd_addr  <= '0;
            r_rd_vld   <= 1'b0;
            r_iss_done <= 1'b0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_id       <= '0;
            r_score    <= '0;
            r_max      <= '0;
            r_idx      <= '0;
        end else if (w_start) begin
            r_busy     <= 1'b1;
            r_valid    <= 1'b0;
            r_raddr    <= '0;
            r_rd_vld   <= 1'b0;
            r_iss_done <= 1'b0;
            r_max      <= MOST_NEG;
            r_idx      <= '0;
        end else begin
            // rd_vld/rd_addr track the address one cycle behind to match SRAM latency
            if (w_issue) begin
                r_rd_vld  <= 1'b1;
                r_rd_addr <= r_raddr;
                if (r_raddr == LAST) r_iss_done <= 1'b1;
                else                 r_raddr    <= r_raddr + 1'b1;
            end else begin
                r_rd_vld <= 1'b0;
            end
            if (r_state == SCAN && r_rd_vld) begin
                r_max <= w_best;
                r_idx <= w_best_id;
            end
            if (w_finish) begin
                r_valid <= 1'b1;
                r_id    <= w_best_id;
                r_score <= w_best;
            end
            if (w_hs) begin
                r_valid <= 1'b0;
                r_busy  <= 1'b0;
            end
        end
    end

    assign bus.sram_raddr_f = r_raddr;
    assign bus.busy         = r_busy;
    assign bus.class_valid  = r_valid;
    assign bus.class_id     = r_id;
    assign bus.class_score  = r_score;
endmodule

// File: tb/tb_fc_argmax.sv
// Directed bench for fc_argmax: registered SRAM model plus hand-computed argmax results.
module tb_fc_argmax;
    logic clk = 1'b0;
    logic srstn;
    logic [31:0] mem [0:3];
    int n_chk = 0;
    int n_pass = 0;

    fc_argmax_if bus ();

    fc_argmax dut (.clk(clk), .srstn(srstn), .bus(bus));

    always #5 clk = ~clk;

    // SRAM f: read data one cycle after the address
    always @(posedge clk) bus.sram_rdata_f <= mem[bus.sram_raddr_f];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic load(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
        mem[0] = w0; mem[1] = w1; mem[2] = w2; mem[3] = 32'h0;
    endtask

    // Pulse fc2_done, wait (bounded) for class_valid and check latency/result
    task automatic scan(input string tag, input logic [3:0] eid, input logic [7:0] esc);
        int lat;
        bus.fc2_done = 1'b1;
        tick();
        bus.fc2_done = 1'b0;
        lat = 1;
        while (!bus.class_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk({tag, ".lat"}, lat, 5);
        chk({tag, ".id"}, {28'h0, bus.class_id}, {28'h0, eid});
        chk({tag, ".score"}, {24'h0, bus.class_score}, {24'h0, esc});
    endtask

    initial begin
        int bad;
        int seen;
        srstn = 1'b0;
        bus.fc2_done = 1'b0;
        bus.class_ready = 1'b1;
        load(32'h0, 32'h0, 32'h0);
        tick(); tick();
        chk("reset", {15'h0, bus.busy, bus.class_valid, bus.class_id, bus.class_score, bus.sram_raddr_f},
            32'h0);
        srstn = 1'b1;
        tick();

        // 1: max class 7 = 100, one-cycle valid with ready high
        load(32'hFB03000C, 32'h80070164, 32'h63FF7F7F);
        scan("t1", 4'd7, 8'h64);
        chk("t1.busy_at_valid", {31'h0, bus.busy}, 32'h1);
        tick();
        chk("t1.valid_drop", {31'h0, bus.class_valid}, 32'h0);
        chk("t1.busy_drop", {31'h0, bus.busy}, 32'h0);
        chk("t1.raddr_hold", {30'h0, bus.sram_raddr_f}, 32'h2);

        // 2: ties resolve to the lowest index; ignored bytes are 7F
        load(32'hFDFDFDFD, 32'hFCFDFDFD, 32'hFDFD7F7F);
        scan("t2", 4'd0, 8'hFD);
        tick();

        // 3: everything most-negative
        load(32'h80808080, 32'h80808080, 32'h80807F7F);
        scan("t3", 4'd0, 8'h80);
        tick();

        // 4: backpressure with an extra fc2_done pulse at cycle 8
        bus.class_ready = 1'b0;
        load(32'hFB03000C, 32'h80070164, 32'h63FF7F7F);
        scan("t4", 4'd7, 8'h64);
        bad = 0;
        for (int c = 5; c < 25; c++) begin
            bus.fc2_done = (c == 8);
            if (!(bus.class_valid && bus.busy && bus.class_id == 4'd7 && bus.class_score == 8'h64))
                bad++;
            tick();
        end
        bus.fc2_done = 1'b0;
        chk("t4.stable", bad, 0);
        chk("t4.raddr", {30'h0, bus.sram_raddr_f}, 32'h2);
        bus.class_ready = 1'b1;
        tick();
        chk("t4.valid_drop", {30'h0, bus.busy, bus.class_valid}, 32'h0);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (bus.class_valid) seen++;
        end
        chk("t4.no_second", seen, 0);

        // 5: reset in the middle of a scan
        bus.fc2_done = 1'b1;
        tick();
        bus.fc2_done = 1'b0;
        tick(); tick();
        srstn = 1'b0;
        #1;
        chk("t5.reset", {15'h0, bus.busy, bus.class_valid, bus.class_id, bus.class_score, bus.sram_raddr_f},
            32'h0);
        tick(); tick();
        srstn = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus.class_valid || bus.busy) seen++;
        end
        chk("t5.no_valid", seen, 0);
        scan("t5b", 4'd7, 8'h64);
        tick();

        // 6: new scan launched in the handshake cycle
        load(32'hFDFDFDFD, 32'hFCFDFDFD, 32'hFDFD7F7F);
        scan("t6a", 4'd0, 8'hFD);
        load(32'h102040F0, 32'h00010203, 32'h3F407F7F);
        bus.fc2_done = 1'b1;
        tick();
        bus.fc2_done = 1'b0;
        chk("t6.c1", {29'h0, bus.class_valid, bus.sram_raddr_f}, {29'h0, 1'b0, 2'd0});
        chk("t6.busy", {31'h0, bus.busy}, 32'h1);
        tick();
        chk("t6.c2", {30'h0, bus.sram_raddr_f}, 32'h1);
        tick();
        chk("t6.c3", {30'h0, bus.sram_raddr_f}, 32'h2);
        tick();
        chk("t6.c4", {31'h0, bus.class_valid}, 32'h0);
        tick();
        chk("t6.c5_valid", {31'h0, bus.class_valid}, 32'h1);
        chk("t6.id", {28'h0, bus.class_id}, 32'h2);
        chk("t6.score", {24'h0, bus.class_score}, 32'h40);
        tick();
        chk("t6.done", {30'h0, bus.busy, bus.class_valid}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
